// File: rtl/apb2ahb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb2ahb_bridge_pkg : shared AHB-Lite encodings and bridge FSM state codes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb2ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/apb2ahb_bridge.sv
// ---------------------------------------------------------------------------
// apb2ahb_bridge : APB3 completer replaying each access as one AHB-Lite SINGLE
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb2ahb_bridge
  import apb2ahb_bridge_pkg::*;
#(
  parameter int          ADDRWIDTH = 16,
  parameter int          DATAWIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic [DATAWIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic                 BUSY
);

  state_e               state_q,   state_d;
  logic [1:0]           htrans_q,  htrans_d;
  logic [31:0]          haddr_q,   haddr_d;
  logic                 hwrite_q,  hwrite_d;
  logic [DATAWIDTH-1:0] wdata_q,   wdata_d;
  logic [DATAWIDTH-1:0] hwdata_q,  hwdata_d;
  logic [DATAWIDTH-1:0] prdata_q,  prdata_d;
  logic                 pslverr_q, pslverr_d;
  logic                 err_q,     err_d;
  logic [31:0]          addr_w;

  // Byte offset is dropped by masking: every transfer is a word access.
  assign addr_w = {BASE_ADDR[31:ADDRWIDTH], PADDR} & 32'hFFFF_FFFC;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      htrans_q  <= HTRANS_IDLE;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      wdata_q   <= '0;
      hwdata_q  <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      wdata_q   <= wdata_d;
      hwdata_q  <= hwdata_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    htrans_d  = htrans_q;
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (PCLKEN && PSEL && !PENABLE) begin
          haddr_d  = addr_w;
          hwrite_d = PWRITE;
          wdata_d  = PWDATA;
          htrans_d = HTRANS_NONSEQ;
          err_d    = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          pslverr_d = (HRESP == HRESP_ERROR);
          if (HRESP == HRESP_OKAY && !hwrite_q) begin
            prdata_d = HRDATA;
          end
          state_d = ST_RESP;
        end else if (HRESP == HRESP_ERROR) begin
          err_d = 1'b1;
        end
      end
      ST_RESP: begin
        // PREADY is held until the APB side actually samples it.
        if (PCLKEN) begin
          pslverr_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign HTRANS  = htrans_q;
  assign HADDR   = haddr_q;
  assign HWRITE  = hwrite_q;
  assign HWDATA  = hwdata_q;
  assign HSIZE   = HSIZE_WORD;
  assign HBURST  = HBURST_SINGLE;
  assign HPROT   = HPROT_VAL;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign PREADY  = (state_q == ST_RESP);
  assign BUSY    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_apb2ahb_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb2ahb_bridge : directed vector table plus hand sequences for the bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb2ahb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        PCLKEN, PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA, HADDR, HWDATA, HRDATA;
  logic        PREADY, PSLVERR, HWRITE, HREADY, HRESP, BUSY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_cmp = 0;
  int n_err = 0;
  int nonseq_cnt = 0;

  always #5 HCLK = ~HCLK;

  apb2ahb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL),
    .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .BUSY(BUSY)
  );

  // Count address phases actually accepted by the AHB side.
  always @(posedge HCLK) begin
    if (HRESETn && HTRANS == 2'b10 && HREADY) nonseq_cnt++;
  end

  typedef struct {
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] exp_haddr;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_access(input vec_t v);
    @(negedge HCLK);
    PCLKEN = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = v.paddr; PWRITE = v.pwrite; PWDATA = v.pwdata;
    HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    check("addr_htrans", {30'd0, HTRANS}, 32'h2);
    check("addr_haddr", HADDR, v.exp_haddr);
    check("addr_hwrite", {31'd0, HWRITE}, {31'd0, v.pwrite});
    check("addr_pready", {31'd0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    for (int i = 0; i < v.aw; i++) begin
      HREADY = 1'b0;
      @(negedge HCLK);
      check("addr_hold", {30'd0, HTRANS}, 32'h2);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    check("data_htrans", {30'd0, HTRANS}, 32'h0);
    if (v.pwrite) check("data_hwdata", HWDATA, v.pwdata);
    for (int i = 0; i < v.dw; i++) begin
      HREADY = 1'b0; HRESP = 1'b0;
      @(negedge HCLK);
      check("data_wait_pready", {31'd0, PREADY}, 32'd0);
    end
    if (v.err) begin
      HREADY = 1'b0; HRESP = 1'b1;
      @(negedge HCLK);
      check("err1_pready", {31'd0, PREADY}, 32'd0);
    end
    HREADY = 1'b1; HRESP = v.err; HRDATA = v.hrdata;
    @(negedge HCLK);
    check("resp_pready", {31'd0, PREADY}, 32'd1);
    check("resp_pslverr", {31'd0, PSLVERR}, {31'd0, v.err});
    check("resp_prdata", PRDATA, v.exp_prdata);
    HRESP = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    check("idle_pready", {31'd0, PREADY}, 32'd0);
    check("idle_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("idle_busy", {31'd0, BUSY}, 32'd0);
    check("idle_prdata", PRDATA, v.exp_prdata);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 32'hAAAA_5555, 0, 0, 1'b0, 32'h4000_0010, 32'h0000_0000};
    vecs[1] = '{1'b0, 16'h0020, 32'h0,         32'h1234_5678, 0, 3, 1'b0, 32'h4000_0020, 32'h1234_5678};
    vecs[2] = '{1'b0, 16'h0013, 32'h0,         32'hCAFE_F00D, 1, 0, 1'b0, 32'h4000_0010, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 16'hFFFC, 32'h0BAD_F00D, 32'h1111_1111, 0, 1, 1'b0, 32'h4000_FFFC, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 16'h0040, 32'h0,         32'h5555_AAAA, 0, 0, 1'b1, 32'h4000_0040, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 16'h0044, 32'h0,         32'h0000_0001, 0, 0, 1'b0, 32'h4000_0044, 32'h0000_0001};

    HRESETn = 1'b0; PCLKEN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(negedge HCLK);
    check("rst_htrans", {30'd0, HTRANS}, 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", {31'd0, HWRITE}, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'h0);
    check("rst_pready", {31'd0, PREADY}, 32'h0);
    check("rst_busy", {31'd0, BUSY}, 32'h0);
    check("const_hsize", {29'd0, HSIZE}, 32'h2);
    check("const_hburst", {29'd0, HBURST}, 32'h0);
    check("const_hprot", {28'd0, HPROT}, 32'h3);
    HRESETn = 1'b1;
    @(negedge HCLK);

    for (int i = 0; i < 6; i++) run_access(vecs[i]);

    // PSEL & PENABLE in IDLE with no setup phase must be ignored.
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 16'h0200; PCLKEN = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      check("noset_busy", {31'd0, BUSY}, 32'd0);
      check("noset_htrans", {30'd0, HTRANS}, 32'd0);
    end
    PSEL = 1'b0; PENABLE = 1'b0;

    // Setup presented with PCLKEN=0 is not sampled; PREADY holds through PCLKEN=0.
    @(negedge HCLK);
    PCLKEN = 1'b0; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0080;
    @(negedge HCLK);
    check("clken0_busy", {31'd0, BUSY}, 32'd0);
    PCLKEN = 1'b1;
    @(negedge HCLK);
    check("clken_haddr", HADDR, 32'h4000_0080);
    check("clken_htrans", {30'd0, HTRANS}, 32'h2);
    PENABLE = 1'b1; PCLKEN = 1'b0; HREADY = 1'b1; HRDATA = 32'hABCD_0123;
    @(negedge HCLK);
    @(negedge HCLK);
    check("clken_pready0", {31'd0, PREADY}, 32'd1);
    check("clken_prdata", PRDATA, 32'hABCD_0123);
    @(negedge HCLK);
    check("clken_pready1", {31'd0, PREADY}, 32'd1);
    @(negedge HCLK);
    check("clken_pready2", {31'd0, PREADY}, 32'd1);
    PCLKEN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    check("clken_done_pready", {31'd0, PREADY}, 32'd0);
    check("clken_done_busy", {31'd0, BUSY}, 32'd0);

    // Reset while the data phase is stalled.
    PCLKEN = 1'b1; PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 16'h0300; PWDATA = 32'h0F0F_0F0F;
    @(negedge HCLK);
    PENABLE = 1'b1; HREADY = 1'b1;
    @(negedge HCLK);
    HREADY = 1'b0;
    check("rstmid_busy_pre", {31'd0, BUSY}, 32'd1);
    HRESETn = 1'b0;
    #1;
    check("rstmid_htrans", {30'd0, HTRANS}, 32'd0);
    check("rstmid_pready", {31'd0, PREADY}, 32'd0);
    check("rstmid_busy", {31'd0, BUSY}, 32'd0);
    check("rstmid_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1; HREADY = 1'b1;
    run_access('{1'b0, 16'h0100, 32'h0, 32'h7654_3210, 0, 0, 1'b0, 32'h4000_0100, 32'h7654_3210});

    repeat (2) @(negedge HCLK);
    check("nonseq_count", nonseq_cnt, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
